dj_weights_ram: RTL
===================

Name: dj_weights_ram

Overview:
- Single-port adjacency-matrix store that answers the Dijkstra engine's weight-row reads.
- Each read returns one whole row: MAX_VIRTEX_NUM weights in parallel, one cycle after chip-select.
- A host loads the matrix one element at a time through a valid/ready write port.
- A built-in clear sequencer initialises the matrix to "no edge" (all-ones) with a zero diagonal.

Parameters:
- MAX_VIRTEX_NUM, 16: number of vertices; matrix is MAX_VIRTEX_NUM x MAX_VIRTEX_NUM; power of 2.
- VIRTEX_DWIDTH, 8: width of one edge weight; all-ones means no edge.
- VIRTEX_AWIDTH, 4: row address width, equal to log2(MAX_VIRTEX_NUM).

Ports:
- clk  in  1  clock; the single clock domain.
- rst  in  1  synchronous, active-high reset.
- weights_ram_addr_i  in  VIRTEX_AWIDTH  row (source vertex) to read.
- weights_ram_cs_i  in  1  read strobe.
- weights_ram_data_o  out  VIRTEX_DWIDTH x MAX_VIRTEX_NUM (unpacked)  row data; element j = weight addr->j.
- rd_err_o  out  1  one-cycle pulse: the read was issued while the clear sequence was running.
- wr_valid_i  in  1  host write request.
- wr_ready_o  out  1  write accepted this cycle.
- wr_row_i  in  VIRTEX_AWIDTH  source vertex.
- wr_col_i  in  VIRTEX_AWIDTH  destination vertex.
- wr_data_i  in  VIRTEX_DWIDTH  weight.
- clr_start_i  in  1  request a full matrix clear.
- clr_busy_o  out  1  clear sequence in progress.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Storage is an array of MAX_VIRTEX_NUM rows, each MAX_VIRTEX_NUM*VIRTEX_DWIDTH bits wide. Array contents are not reset directly.
- Reset values:
  - weights_ram_data_o = all zeros; rd_err_o = 0; wr_ready_o = 0.
  - clr_busy_o = 1 in the first cycle after rst deasserts (reset enters CLEAR).
- FSM states: IDLE, CLEAR, WR2. WR2 exists only with the optional feature.
- CLEAR:
  - Row counter runs 0..MAX_VIRTEX_NUM-1, writing one row per cycle.
  - Row r gets all-ones in every element except element r, which gets 0.
  - Takes exactly MAX_VIRTEX_NUM cycles, then goes to IDLE. clr_busy_o is high for exactly those cycles.
  - clr_start_i is ignored while in CLEAR; the counter does not restart.
  - clr_start_i in IDLE enters CLEAR on the next cycle. A write presented in the same cycle is not accepted.
- Read (any state):
  - cs high at cycle T: weights_ram_data_o shows row addr at T+1 and holds until the next cs.
  - Data reflects array contents at the end of cycle T. A write accepted in cycle T is not visible; it becomes visible to reads at T+1 or later.
  - cs during CLEAR: data_o = all-ones, rd_err_o = 1 at T+1, and the clear continues uninterrupted.
  - Back-to-back cs every cycle is supported at full rate.
- Write (IDLE only):
  - wr_ready_o = wr_valid_i & IDLE & ~weights_ram_cs_i & ~clr_start_i. Read has priority over write on the single port.
  - A handshake (valid & ready) writes element [row][col] = data; all other elements of the row are preserved (read-modify-write of the row word).
  - The host holds valid and its fields stable until ready. Fields may change freely after the handshake.
  - Diagonal writes are stored as given.
- Simultaneous events:
  - rst overrides everything, including mid-clear and mid-WR2.
  - clr_start_i in the same cycle as cs: the read completes normally (IDLE read), and CLEAR starts on the next cycle.

Optional Feature:
- DJ_SYMMETRIC_EN defined:
  - Each accepted write to [r][c] with r != c is followed, in state WR2, by a write of the same data to [c][r].
  - wr_ready_o is low in WR2.
  - If cs is high in WR2, the read is served and WR2 stalls (stays in WR2) until a cycle with cs low. A read of row c before the mirror completes returns the old value.
  - Diagonal writes skip WR2.
- DJ_SYMMETRIC_EN undefined: the WR2 state and mirror logic are absent, and writes are single-element only.

Test Plan:
- Reset, then wait: clr_busy_o high for 16 cycles. Then read row 5 -> element 5 = 0x00, all others 0xFF.
- After clear, write [2][7]=0x0A, then cs addr=2 -> next cycle element 7 = 0x0A, others unchanged (element 2 = 0x00, rest 0xFF).
- Hold wr_valid with [3][1]=0x05 while cs is high for 3 consecutive cycles -> wr_ready_o stays 0 for those 3 cycles and goes 1 on the first cycle cs is low. A following read of row 3 gives element 1 = 0x05.
- Assert clr_start_i, then cs addr=0 on the 4th cycle of CLEAR -> data = all 0xFF and rd_err_o pulses once. The clear still finishes after 16 cycles.
- Assert rst in the middle of CLEAR -> all outputs return to reset values, and a fresh 16-cycle clear runs.
- With DJ_SYMMETRIC_EN: write [4][9]=0x11 -> wr_ready_o is low the next cycle. Reads of rows 4 and 9 return 0x11 at elements 9 and 4 respectively.

Source files
------------

// File: rtl/dj_weights_ram.sv
// rtl/dj_weights_ram.sv - Dijkstra adjacency-matrix row store with host write port and clear sequencer; optional mirror writes under DJ_SYMMETRIC_EN
module dj_weights_ram #(
    parameter int MAX_VIRTEX_NUM = 16,
    parameter int VIRTEX_DWIDTH  = 8,
    parameter int VIRTEX_AWIDTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [VIRTEX_AWIDTH-1:0] weights_ram_addr_i,
    input  logic                     weights_ram_cs_i,
    output logic [VIRTEX_DWIDTH-1:0] weights_ram_data_o [MAX_VIRTEX_NUM],
    output logic                     rd_err_o,
    input  logic                     wr_valid_i,
    output logic                     wr_ready_o,
    input  logic [VIRTEX_AWIDTH-1:0] wr_row_i,
    input  logic [VIRTEX_AWIDTH-1:0] wr_col_i,
    input  logic [VIRTEX_DWIDTH-1:0] wr_data_i,
    input  logic                     clr_start_i,
    output logic                     clr_busy_o
);

    localparam int ROW_W = MAX_VIRTEX_NUM * VIRTEX_DWIDTH;
    localparam logic [VIRTEX_AWIDTH-1:0] LAST_ROW = VIRTEX_AWIDTH'(MAX_VIRTEX_NUM - 1);

`ifdef DJ_SYMMETRIC_EN
    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_WR2} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_CLEAR} state_t;
`endif

    state_t                   state_q;
    state_t                   state_d;
    logic [ROW_W-1:0]         mem [MAX_VIRTEX_NUM];
    logic [VIRTEX_AWIDTH-1:0] clr_cnt;
    logic                     mem_we;
    logic [VIRTEX_AWIDTH-1:0] mem_waddr;
    logic [ROW_W-1:0]         mem_wdata;
    logic [ROW_W-1:0]         clr_word;
    logic [ROW_W-1:0]         host_word;

`ifdef DJ_SYMMETRIC_EN
    logic [VIRTEX_AWIDTH-1:0] mir_row;
    logic [VIRTEX_AWIDTH-1:0] mir_col;
    logic [VIRTEX_DWIDTH-1:0] mir_data;
    logic [ROW_W-1:0]         mir_word;
`endif

    assign clr_busy_o = (state_q == S_CLEAR);
    // Reads own the single port, and a pending clear request beats a write.
    assign wr_ready_o = wr_valid_i & ~rst & (state_q == S_IDLE) & ~weights_ram_cs_i & ~clr_start_i;

    // Row words: clear pattern for the current row and read-modify-write merges.
    always_comb begin
        clr_word = '1;
        for (int j = 0; j < MAX_VIRTEX_NUM; j++) begin
            if (j == int'(clr_cnt)) clr_word[j*VIRTEX_DWIDTH +: VIRTEX_DWIDTH] = '0;
        end
        host_word = mem[wr_row_i];
        host_word[int'(wr_col_i)*VIRTEX_DWIDTH +: VIRTEX_DWIDTH] = wr_data_i;
`ifdef DJ_SYMMETRIC_EN
        mir_word = mem[mir_row];
        mir_word[int'(mir_col)*VIRTEX_DWIDTH +: VIRTEX_DWIDTH] = mir_data;
`endif
    end

    // Next state and the single write port mux.
    always_comb begin
        state_d   = state_q;
        mem_we    = 1'b0;
        mem_waddr = clr_cnt;
        mem_wdata = clr_word;
        case (state_q)
            S_CLEAR: begin
                mem_we = 1'b1;
                if (clr_cnt == LAST_ROW) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (clr_start_i) begin
                    state_d = S_CLEAR;
                end else if (wr_ready_o) begin
                    mem_we    = 1'b1;
                    mem_waddr = wr_row_i;
                    mem_wdata = host_word;
`ifdef DJ_SYMMETRIC_EN
                    if (wr_row_i != wr_col_i) state_d = S_WR2;
`endif
                end
            end
`ifdef DJ_SYMMETRIC_EN
            S_WR2: begin
                // A read holds the port; the mirror write waits for a free cycle.
                if (!weights_ram_cs_i) begin
                    mem_we    = 1'b1;
                    mem_waddr = mir_row;
                    mem_wdata = mir_word;
                    state_d   = S_IDLE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // State register and clear row counter; reset always starts a fresh clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_CLEAR;
            clr_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_CLEAR) clr_cnt <= clr_cnt + 1'b1;
            else                    clr_cnt <= '0;
        end
    end

`ifdef DJ_SYMMETRIC_EN
    // Capture the transposed coordinates of an accepted write for the mirror pass.
    always_ff @(posedge clk) begin
        if (wr_ready_o) begin
            mir_row  <= wr_col_i;
            mir_col  <= wr_row_i;
            mir_data <= wr_data_i;
        end
    end
`endif

    // Matrix storage, written one whole row per cycle.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    // Row read: registered one cycle after chip-select, held until the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < MAX_VIRTEX_NUM; j++) weights_ram_data_o[j] <= '0;
            rd_err_o <= 1'b0;
        end else begin
            rd_err_o <= weights_ram_cs_i & (state_q == S_CLEAR);
            if (weights_ram_cs_i) begin
                for (int j = 0; j < MAX_VIRTEX_NUM; j++) begin
                    weights_ram_data_o[j] <= (state_q == S_CLEAR) ? '1
                                             : mem[weights_ram_addr_i][j*VIRTEX_DWIDTH +: VIRTEX_DWIDTH];
                end
            end
        end
    end

endmodule
